// File: rtl/bitslice_pkg.sv
// Shared types and constants for the bit-slice register file / write-back stage.
package bitslice_pkg;

   localparam int unsigned NREG   = 16;
   localparam int unsigned ADDR_W = 4;
   // Widest result the S1 record can carry; the top narrows it to its own W.
   localparam int unsigned MAX_W  = 32;

   typedef enum logic [1:0] {
      StIdle,
      StDrain,
      StClear
   } state_e;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [MAX_W-1:0]  sum;
      logic              carry;
      logic              we;
      logic              fe;
      logic              kill;
   } wb_req_t;

endpackage

// File: rtl/bitslice_rf_array.sv
// 16 x W register storage: one write port, flat read-out to the slice mux and one muxed read.
module bitslice_rf_array
   import bitslice_pkg::*;
#(
   parameter int unsigned W         = 1,
   parameter bit          REG0_ZERO = 1'b1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                we_i,
   input  logic [ADDR_W-1:0]   waddr_i,
   input  logic [W-1:0]        wdata_i,
   input  logic [ADDR_W-1:0]   raddr_i,
   output logic [W-1:0]        rdata_o,
   output logic [NREG*W-1:0]   flat_o
);

   for (genvar i = 0; i < NREG; i++) begin : g_entry
      logic [W-1:0] entry_q;
      if (i == 0 && REG0_ZERO) begin : g_zero
         assign entry_q = '0;
      end else begin : g_reg
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               entry_q <= '0;
            end else if (we_i && (waddr_i == ADDR_W'(i))) begin
               entry_q <= wdata_i;
            end
         end
      end
      assign flat_o[i*W +: W] = entry_q;
   end

   assign rdata_o = flat_o[raddr_i*W +: W];

endmodule

// File: rtl/bitslice_regfile_wb.sv
// Register file and write-back stage feeding the bit-slice ALU: one-deep S1 commit stage,
// bypassed debug read, saturating commit counter and a drain-then-clear sequencer.
module bitslice_regfile_wb
   import bitslice_pkg::*;
#(
   parameter int unsigned W         = 1,
   parameter bit          REG0_ZERO = 1'b1,
   parameter int unsigned CNT_W     = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [ADDR_W-1:0]   in_addr,
   input  logic [W-1:0]        in_sum,
   input  logic                in_carry,
   input  logic                in_we,
   input  logic                in_fe,
   input  logic                in_kill,
   output logic [NREG*W-1:0]   rf_q,
   output logic                carry_q,
   input  logic [ADDR_W-1:0]   rd_addr,
   output logic [W-1:0]        rd_data,
   input  logic                clr_req,
   output logic                clr_done,
   output logic                busy,
   output logic [CNT_W-1:0]    wb_count
);

   state_e            state_q;
   logic [ADDR_W-1:0] idx_q;
   wb_req_t           s1_q;
   logic              s1_valid_q;

   logic              accept;
   logic              commit;
   logic              commit_wr;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [W-1:0]      wr_data;
   logic [W-1:0]      arr_rdata;

   assign in_ready = (state_q == StIdle) & ~clr_req;
   assign accept   = in_valid & in_ready;
   assign commit   = s1_valid_q & ~s1_q.kill;
   // Entry 0 writes are dropped entirely, so they neither land nor count.
   assign commit_wr = commit & s1_q.we & ~(REG0_ZERO && (s1_q.addr == '0));
   assign busy      = (state_q != StIdle) | s1_valid_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_q       <= '0;
      end else begin
         s1_valid_q <= accept;
         if (accept) begin
            s1_q.addr  <= in_addr;
            s1_q.sum   <= MAX_W'(in_sum);
            s1_q.carry <= in_carry;
            s1_q.we    <= in_we;
            s1_q.fe    <= in_fe;
            s1_q.kill  <= in_kill;
         end
      end
   end

   // S1 is always empty while clearing, so the clear can own the single write port.
   always_comb begin
      wr_en   = commit_wr;
      wr_addr = s1_q.addr;
      wr_data = W'(s1_q.sum);
      if (state_q == StClear) begin
         wr_en   = 1'b1;
         wr_addr = idx_q;
         wr_data = '0;
      end
   end

   bitslice_rf_array #(
      .W         (W),
      .REG0_ZERO (REG0_ZERO)
   ) u_rf_array (
      .clk     (clk),
      .rst_n   (rst_n),
      .we_i    (wr_en),
      .waddr_i (wr_addr),
      .wdata_i (wr_data),
      .raddr_i (rd_addr),
      .rdata_o (arr_rdata),
      .flat_o  (rf_q)
   );

   assign rd_data = (commit_wr && (s1_q.addr == rd_addr)) ? W'(s1_q.sum) : arr_rdata;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         carry_q <= 1'b0;
      end else if ((state_q == StClear) && (idx_q == '0)) begin
         carry_q <= 1'b0;
      end else if (commit && s1_q.fe) begin
         carry_q <= s1_q.carry;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_count <= '0;
      end else if (commit_wr && (wb_count != '1)) begin
         wb_count <= wb_count + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         idx_q    <= '0;
         clr_done <= 1'b0;
      end else begin
         clr_done <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (clr_req) state_q <= StDrain;
            end
            StDrain: begin
               if (!s1_valid_q) begin
                  state_q <= StClear;
                  idx_q   <= '0;
               end
            end
            StClear: begin
               idx_q <= idx_q + 1'b1;
               if (idx_q == ADDR_W'(NREG - 1)) begin
                  state_q  <= StIdle;
                  clr_done <= 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_bitslice_regfile_wb.sv
// Directed bench for bitslice_regfile_wb; a second instance with a 4-bit counter checks saturation.
module tb_bitslice_regfile_wb;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [3:0]  in_addr;
   logic [0:0]  in_sum;
   logic        in_carry;
   logic        in_we;
   logic        in_fe;
   logic        in_kill;
   logic [3:0]  rd_addr;
   logic        clr_req;

   logic        in_ready,  in_ready4;
   logic [15:0] rf_q,      rf_q4;
   logic        carry_q,   carry_q4;
   logic [0:0]  rd_data,   rd_data4;
   logic        clr_done,  clr_done4;
   logic        busy,      busy4;
   logic [15:0] wb_count;
   logic [3:0]  wb_count4;

   int n_checks = 0;
   int n_errors = 0;

   bitslice_regfile_wb #(.W(1), .REG0_ZERO(1'b1), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
      .in_sum(in_sum), .in_carry(in_carry), .in_we(in_we), .in_fe(in_fe), .in_kill(in_kill),
      .rf_q(rf_q), .carry_q(carry_q), .rd_addr(rd_addr), .rd_data(rd_data), .clr_req(clr_req),
      .clr_done(clr_done), .busy(busy), .wb_count(wb_count)
   );

   bitslice_regfile_wb #(.W(1), .REG0_ZERO(1'b1), .CNT_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4), .in_addr(in_addr),
      .in_sum(in_sum), .in_carry(in_carry), .in_we(in_we), .in_fe(in_fe), .in_kill(in_kill),
      .rf_q(rf_q4), .carry_q(carry_q4), .rd_addr(rd_addr), .rd_data(rd_data4), .clr_req(clr_req),
      .clr_done(clr_done4), .busy(busy4), .wb_count(wb_count4)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Advance one clock; inputs and samples then sit 1 ns after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [3:0] a, input logic s, input logic c,
                        input logic we, input logic fe, input logic k);
      in_valid = v; in_addr = a; in_sum = s; in_carry = c; in_we = we; in_fe = fe; in_kill = k;
   endtask

   int pulses;
   int waited;

   initial begin
      rst_n = 1'b0; clr_req = 1'b0; rd_addr = 4'd0;
      drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      #8;
      check("reset_rf", 32'(rf_q), 32'h0);
      check("reset_carry", 32'(carry_q), 32'h0);
      check("reset_count", 32'(wb_count), 32'h0);
      check("reset_busy_done", {busy, clr_done}, 32'h0);
      #4 rst_n = 1'b1;
      #1 check("ready_after_reset", 32'(in_ready), 32'h1);

      // Single commit: visible only after the second edge.
      step();
      drive(1'b1, 4'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      step();
      drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("k_entry5", 32'(rf_q[5]), 32'h0);
      check("k_carry", 32'(carry_q), 32'h0);
      step();
      check("k1_entry5", 32'(rf_q[5]), 32'h1);
      check("k1_carry", 32'(carry_q), 32'h1);
      check("k1_count", 32'(wb_count), 32'h1);

      // Back-to-back writes to entry 3 with the bypass watching it.
      rd_addr = 4'd3;
      drive(1'b1, 4'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      step();
      in_sum = 1'b0;
      #1 check("bypass_first", 32'(rd_data), 32'h1);
      check("bypass_first_rf", 32'(rf_q[3]), 32'h0);
      step();
      drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      #1 check("bypass_second", 32'(rd_data), 32'h0);
      check("bypass_second_rf", 32'(rf_q[3]), 32'h1);
      step();
      check("b2b_entry3", 32'(rf_q[3]), 32'h0);
      check("b2b_count", 32'(wb_count), 32'h3);

      // Entry 0 write is dropped and not counted; bypass must not expose it.
      rd_addr = 4'd0;
      drive(1'b1, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      step();
      drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      #1 check("reg0_bypass", 32'(rd_data), 32'h0);
      step();
      check("reg0_entry", 32'(rf_q[0]), 32'h0);
      check("reg0_count", 32'(wb_count), 32'h3);

      // Killed result changes nothing.
      drive(1'b1, 4'd7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      step();
      drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      check("kill_entry7", 32'(rf_q[7]), 32'h0);
      check("kill_carry", 32'(carry_q), 32'h1);
      check("kill_count", 32'(wb_count), 32'h3);

      // Clear request while S1 is full and a new result is offered.
      drive(1'b1, 4'd9, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      step();
      drive(1'b1, 4'd10, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      clr_req = 1'b1;
      #1 check("clr_ready_low", 32'(in_ready), 32'h0);
      step();
      clr_req = 1'b0;
      drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("clr_s1_commit", 32'(rf_q[9]), 32'h1);
      check("clr_busy", 32'(busy), 32'h1);
      waited = 0;
      while (clr_done !== 1'b1 && waited < 40) begin
         step();
         waited++;
      end
      check("clr_cycles", 32'(waited), 32'd17);
      check("clr_rf", 32'(rf_q), 32'h0);
      check("clr_carry", 32'(carry_q), 32'h0);
      check("clr_count", 32'(wb_count), 32'h4);
      step();
      check("clr_done_once", 32'(clr_done), 32'h0);
      check("clr_idle", {busy, in_ready}, 32'h1);

      // Reset in the middle of a clear.
      drive(1'b1, 4'd12, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      step();
      drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      clr_req = 1'b1;
      step();
      clr_req = 1'b0;
      for (int i = 0; i < 9; i++) step();
      check("midclr_entry12", 32'(rf_q[12]), 32'h1);
      #1 rst_n = 1'b0;
      #1 check("midclr_rst_rf", 32'(rf_q), 32'h0);
      check("midclr_rst_count", 32'(wb_count), 32'h0);
      check("midclr_rst_flags", {carry_q, busy, clr_done}, 32'h0);
      #10 rst_n = 1'b1;
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (clr_done === 1'b1) pulses++;
      end
      check("midclr_no_done", 32'(pulses), 32'h0);
      check("midclr_idle", {busy, in_ready}, 32'h1);

      // Counter saturation on the 4-bit instance.
      drive(1'b1, 4'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 16; i++) step();
      drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      check("sat_count4", 32'(wb_count4), 32'hf);
      check("sat_count16", 32'(wb_count), 32'd16);
      drive(1'b1, 4'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      step();
      drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      check("sat_hold4", 32'(wb_count4), 32'hf);
      check("sat_count16_more", 32'(wb_count), 32'd17);
      check("sat_entry2", 32'(rf_q4[2]), 32'h1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
